// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: ALU opcodes,
// FSM state encoding, iteration count and the latched request descriptor.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ITER = 32;
  localparam int unsigned OPW  = 5;
  localparam int unsigned CNTW = $clog2(ITER);

  localparam logic [OPW-1:0] OP_MUL    = 5'b01011;
  localparam logic [OPW-1:0] OP_MULH   = 5'b01100;
  localparam logic [OPW-1:0] OP_MULHSU = 5'b01101;
  localparam logic [OPW-1:0] OP_MULHU  = 5'b01110;
  localparam logic [OPW-1:0] OP_DIV    = 5'b01111;
  localparam logic [OPW-1:0] OP_DIVU   = 5'b10000;
  localparam logic [OPW-1:0] OP_REM    = 5'b10001;
  localparam logic [OPW-1:0] OP_REMU   = 5'b10010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Operation descriptor captured on the accepting edge.
  typedef struct packed {
    logic [OPW-1:0]  op;
    logic            neg_res;
    logic            neg_a;
    logic            bypass;
    logic [XLEN-1:0] special;
  } ctrl_t;

  function automatic logic is_muldiv_op(input logic [OPW-1:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Radix-2 iterative datapath: LSB-first shift-add multiply and restoring
// shift-subtract divide over one 64-bit accumulator ({rem, quot} for divide).
module muldiv_core
  import muldiv_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic                is_div,
  input  logic [XLEN-1:0]     op_a,
  input  logic [XLEN-1:0]     op_b,
  output logic [2*XLEN-1:0]   acc
);

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   b_q;
  logic              div_q;

  logic [2*XLEN-1:0] cur_p;
  logic [XLEN-1:0]   cur_b;
  logic              cur_div;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     rem_sh;
  logic              ge;
  logic [XLEN-1:0]   rem_nxt;
  logic [2*XLEN-1:0] next_p;

  // The load edge performs the first step directly on the fresh operands.
  always_comb begin
    cur_p   = load ? {XLEN'(0), op_a} : acc_q;
    cur_b   = load ? op_b : b_q;
    cur_div = load ? is_div : div_q;

    sum     = {1'b0, cur_p[2*XLEN-1:XLEN]} + (cur_p[0] ? {1'b0, cur_b} : (XLEN+1)'(0));

    rem_sh  = {cur_p[2*XLEN-1:XLEN], cur_p[XLEN-1]};
    ge      = (rem_sh >= {1'b0, cur_b});
    rem_nxt = ge ? (rem_sh[XLEN-1:0] - cur_b) : rem_sh[XLEN-1:0];

    if (cur_div) begin
      next_p = {rem_nxt, cur_p[XLEN-2:0], ge};
    end else begin
      next_p = {sum, cur_p[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      acc_q <= next_p;
      b_q   <= op_b;
      div_q <= is_div;
    end else if (step) begin
      acc_q <= next_p;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/DIV sequencer: request acceptance, operand sign handling,
// divide special cases and final sign fix around the iterative core.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [OPW-1:0]  SELECT,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  state_t            state;
  logic [CNTW-1:0]   cnt;
  ctrl_t             ctrl_q;

  logic              signed_a;
  logic              signed_b;
  logic              neg_a;
  logic              neg_b;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              is_div_op;
  logic              div_zero;
  logic              ovf;
  logic [XLEN-1:0]   special;
  logic              accept;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fin_result;

  // Request decode: operand signedness, magnitudes and bypass cases.
  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (SELECT)
      OP_MULH:        begin signed_a = 1'b1; signed_b = 1'b1; end
      OP_MULHSU:      signed_a = 1'b1;
      OP_DIV, OP_REM: begin signed_a = 1'b1; signed_b = 1'b1; end
      default:        ;
    endcase

    neg_a     = signed_a & DATA1[XLEN-1];
    neg_b     = signed_b & DATA2[XLEN-1];
    mag_a     = neg_a ? (~DATA1 + XLEN'(1)) : DATA1;
    mag_b     = neg_b ? (~DATA2 + XLEN'(1)) : DATA2;

    is_div_op = (SELECT >= OP_DIV) && (SELECT <= OP_REMU);
    div_zero  = is_div_op && (DATA2 == '0);
    ovf       = ((SELECT == OP_DIV) || (SELECT == OP_REM)) &&
                (DATA1 == 32'h8000_0000) && (DATA2 == 32'hFFFF_FFFF);

    special = '0;
    if (div_zero) begin
      special = ((SELECT == OP_DIV) || (SELECT == OP_DIVU)) ? '1 : DATA1;
    end else if (ovf) begin
      special = (SELECT == OP_DIV) ? 32'h8000_0000 : '0;
    end

    accept = START && !FLUSH && (state == IDLE) && is_muldiv_op(SELECT);
  end

  muldiv_core u_core (
    .clk    (CLK),
    .rst    (RESET),
    .load   (accept),
    .step   (state == CALC),
    .is_div (is_div_op),
    .op_a   (mag_a),
    .op_b   (mag_b),
    .acc    (acc)
  );

  // Two's-complement fix-up of the unsigned core result.
  always_comb begin
    prod_fix = ctrl_q.neg_res ? (~acc + 64'd1) : acc;
    quot_fix = ctrl_q.neg_res ? (~acc[XLEN-1:0] + XLEN'(1)) : acc[XLEN-1:0];
    rem_fix  = ctrl_q.neg_a ? (~acc[2*XLEN-1:XLEN] + XLEN'(1)) : acc[2*XLEN-1:XLEN];
    case (ctrl_q.op)
      OP_MUL:                       fin_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fin_result = quot_fix;
      default:                      fin_result = rem_fix;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      cnt    <= '0;
      ctrl_q <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      RESULT <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            ctrl_q.op      <= SELECT;
            ctrl_q.neg_res <= neg_a ^ neg_b;
            ctrl_q.neg_a   <= neg_a;
            ctrl_q.bypass  <= div_zero | ovf;
            ctrl_q.special <= special;
            cnt            <= '0;
            BUSY           <= 1'b1;
            state          <= (div_zero | ovf) ? FIN : CALC;
          end
        end
        // The accept edge already ran one step, so CALC holds ITER-1 cycles.
        CALC: begin
          if (FLUSH) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end else if (cnt == CNTW'(ITER - 2)) begin
            state <= FIN;
          end else begin
            cnt <= CNTW'(cnt + 1'b1);
          end
        end
        FIN: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          if (!FLUSH) begin
            RESULT <= ctrl_q.bypass ? ctrl_q.special : fin_result;
            DONE   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed vectors, control corner
// cases and randomized operations against an arithmetic reference model.
module tb_muldiv_sequencer;

  localparam logic [4:0] T_MUL    = 5'b01011;
  localparam logic [4:0] T_MULH   = 5'b01100;
  localparam logic [4:0] T_MULHSU = 5'b01101;
  localparam logic [4:0] T_MULHU  = 5'b01110;
  localparam logic [4:0] T_DIV    = 5'b01111;
  localparam logic [4:0] T_DIVU   = 5'b10000;
  localparam logic [4:0] T_REM    = 5'b10001;
  localparam logic [4:0] T_REMU   = 5'b10010;

  logic        CLK = 1'b0;
  logic        RESET, START, FLUSH;
  logic [4:0]  SELECT;
  logic [31:0] DATA1, DATA2;
  logic        BUSY, DONE;
  logic [31:0] RESULT;

  muldiv_sequencer dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .SELECT (SELECT),
    .DATA1  (DATA1),
    .DATA2  (DATA2),
    .FLUSH  (FLUSH),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .RESULT (RESULT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_res = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_bypass(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if ((op == T_DIV || op == T_DIVU || op == T_REM || op == T_REMU) && b == 0) return 1'b1;
    if ((op == T_DIV || op == T_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: plain 64-bit arithmetic on signed/unsigned interpretations.
  function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          ia, ib, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    ia = int'(a);
    ib = int'(b);
    case (op)
      T_MUL:    begin p = 64'(ua * ub); return p[31:0]; end
      T_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      T_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      T_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
      T_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (is_bypass(op, a, b)) return 32'h8000_0000;
        r = ia / ib;
        return 32'(r);
      end
      T_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      T_REM: begin
        if (b == 0) return a;
        if (is_bypass(op, a, b)) return 32'h0;
        r = ia % ib;
        return 32'(r);
      end
      T_REMU:   return (b == 0) ? a : a % b;
      default:  return 32'h0;
    endcase
  endfunction

  // Called at #1 after a rising edge; START is sampled on the next edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] exp_res);
    exp_t e;
    START  = 1'b1;
    SELECT = op;
    DATA1  = a;
    DATA2  = b;
    if (push) begin
      e.res = exp_res;
      e.at  = cyc + (is_bypass(op, a, b) ? 2 : 33);
      sbq.push_back(e);
      last_res = exp_res;
    end
    @(posedge CLK); #1;
    START  = 1'b0;
    SELECT = 5'($urandom);
    DATA1  = $urandom;
    DATA2  = $urandom;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge CLK); #1;
      if (DONE) seen = 1'b1;
    end
    chk({name, "_done_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every DONE pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (RESET !== 1'b1 && DONE === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: DONE=1 at cycle %0d, required 0 (nothing pending)", cyc);
      end else begin
        e = sbq.pop_front();
        chk("result", 64'(RESULT), 64'(e.res));
        chk("done_cycle", 64'(cyc), 64'(e.at));
        chk("busy_in_done_cycle", 64'(BUSY), 64'd0);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  initial begin : stim
    vec_t vecs[$];
    int   nb;
    bit   seen;
    logic [4:0]  op;
    logic [31:0] a, b;

    RESET = 1'b1; START = 1'b0; FLUSH = 1'b0;
    SELECT = '0; DATA1 = '0; DATA2 = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_busy", 64'(BUSY), 64'd0);
    chk("reset_done", 64'(DONE), 64'd0);
    chk("reset_result", 64'(RESULT), 64'd0);
    RESET = 1'b0;
    idle(1);

    // MUL 10 x 20 with BUSY occupancy measured up to DONE.
    issue(T_MUL, 32'd10, 32'd20, 1'b1, 32'd200);
    nb = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (BUSY) nb++;
      if (DONE) seen = 1'b1;
      else begin
        @(posedge CLK); #1;
      end
    end
    chk("mul_done_seen", 64'(seen), 64'd1);
    chk("mul_busy_cycles", 64'(nb), 64'd32);

    vecs.push_back('{T_MULH,   32'd4,          32'hFFFF_FFFF, 32'hFFFF_FFFF});
    vecs.push_back('{T_MULHU,  32'd4,          32'hFFFF_FFFF, 32'h0000_0003});
    vecs.push_back('{T_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF});
    vecs.push_back('{T_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD});
    vecs.push_back('{T_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF});
    vecs.push_back('{T_DIVU,   32'd20,         32'd3,         32'd6});
    vecs.push_back('{T_REMU,   32'd20,         32'd3,         32'd2});
    vecs.push_back('{T_DIVU,   32'd20,         32'd0,         32'hFFFF_FFFF});
    vecs.push_back('{T_REMU,   32'd20,         32'd0,         32'd20});
    vecs.push_back('{T_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});
    vecs.push_back('{T_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{T_MUL,    32'd3,          32'd5,         32'd15});
    // Each next START is driven in the DONE cycle of the previous one.
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].r);
      wait_done("vector");
    end
    idle(2);

    // Unsupported opcode is ignored.
    START = 1'b1; SELECT = 5'b00001; DATA1 = 32'd9; DATA2 = 32'd9;
    idle(1);
    START = 1'b0;
    chk("bad_select_busy", 64'(BUSY), 64'd0);
    idle(5);

    // START while BUSY is ignored; first operation completes undisturbed.
    issue(T_MUL, 32'd7, 32'd9, 1'b1, 32'd63);
    idle(3);
    START = 1'b1; SELECT = T_DIVU; DATA1 = 32'd100; DATA2 = 32'd10;
    idle(1);
    START = 1'b0;
    wait_done("busy_start");
    idle(40);

    // FLUSH with START in IDLE drops the request.
    FLUSH = 1'b1; START = 1'b1; SELECT = T_MUL; DATA1 = 32'd2; DATA2 = 32'd2;
    idle(1);
    FLUSH = 1'b0; START = 1'b0;
    chk("flush_start_busy", 64'(BUSY), 64'd0);
    idle(40);

    // FLUSH on the 10th CALC cycle of a DIV.
    issue(T_DIV, 32'd1000, 32'd7, 1'b0, 32'd0);
    idle(9);
    FLUSH = 1'b1;
    idle(1);
    FLUSH = 1'b0;
    chk("flush_busy", 64'(BUSY), 64'd0);
    chk("flush_result_kept", 64'(RESULT), 64'(last_res));
    idle(40);
    chk("flush_result_later", 64'(RESULT), 64'(last_res));

    // RESET on the 5th CALC cycle of a MUL.
    issue(T_MUL, 32'd123, 32'd456, 1'b0, 32'd0);
    idle(4);
    RESET = 1'b1;
    idle(1);
    chk("midop_reset_busy", 64'(BUSY), 64'd0);
    chk("midop_reset_done", 64'(DONE), 64'd0);
    chk("midop_reset_result", 64'(RESULT), 64'd0);
    RESET = 1'b0;
    last_res = '0;
    idle(40);

    // Randomized operations against the reference model.
    for (int n = 0; n < 60; n++) begin
      op = 5'(T_MUL + 5'($urandom_range(0, 7)));
      a  = pick();
      b  = pick();
      issue(op, a, b, 1'b1, ref_res(op, a, b));
      wait_done("random");
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(5);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
